fwft_fifo_param: RTL

- Parametrised first-word-fall-through FIFO; successor to the fixed 8-bit/66-entry LED-board FIFO.
- Adds:
  - generic width and depth, including non-power-of-2 depth;
  - true FWFT head-of-queue presentation;
  - occupancy count;
  - programmable almost-full/almost-empty flags;
  - sticky overflow/underflow error flags.
- Single clock domain. Sits between the LED-board data source and the frame/shift-out logic.

---
 rtl/fwft_fifo_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fwft_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fwft_fifo_param
// Purpose  : Parametrised first-word-fall-through FIFO for the LED-board data
//            path. The head-of-queue word is held in a register so it is
//            visible one edge after being written into an empty FIFO, with no
//            read needed to fetch it. Depth can be any integer >= 2.
// Ports    : clk, rst (async, active-high)
//            i_wr_en / i_wr_data        write request and data
//            i_rd_en                    pop / acknowledge of o_rd_data
//            i_err_clr                  synchronous clear of sticky errors
//            o_rd_data                  head word, valid while o_empty = 0
//            o_full / o_empty           count == DEPTH / count == 0
//            o_almost_full / _empty     count >= AFULL / count <= AEMPTY
//            o_count                    words held, head included
//            o_overflow / o_underflow   sticky write-while-full / read-while-empty
// Revision : 1.0 - initial parametrised release
// ============================================================================
module fwft_fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 66,
    parameter int AFULL_THRESH  = 64,
    parameter int AEMPTY_THRESH = 2,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int          c_PW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // All flags come from the registered count only.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Write is refused when full even if a pop happens on the same edge.
    assign w_wr_acc = i_wr_en & ~w_full;
    assign w_rd_acc = i_rd_en & ~w_empty;

    // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PW'(1);

    // The storage array holds every queued word including the head; r_head
    // is a registered copy of the word at r_rd_ptr so o_rd_data never sees
    // a combinational path from the request inputs.
    always_comb begin
        w_head_nxt = r_head;
        if (w_rd_acc) begin
            if (r_count == CW'(1)) begin
                // Last word leaves; a same-edge write becomes the new head.
                if (w_wr_acc) begin
                    w_head_nxt = i_wr_data;
                end
            end else begin
                // With two or more words the successor is already stored and
                // cannot collide with this edge's write location.
                w_head_nxt = r_mem[w_rd_ptr_nxt];
            end
        end else if (w_wr_acc && w_empty) begin
            w_head_nxt = i_wr_data;
        end
    end

    // Storage is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_head <= w_head_nxt;

            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A new violation takes priority over a clear in the same cycle.
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end

            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (i_err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_rd_data      = r_head;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CW'(AFULL_THRESH));
    assign o_almost_empty = (r_count <= CW'(AEMPTY_THRESH));
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
`default_nettype wire
